hazard_ctrl: RTL and testbench

Pipeline stall and D-stage forwarding controller for the 5-stage MIPS core. It drives the core's `en_PC`, `en_D` and `clr` inputs, and the D-stage comparator forwarding selects. It decodes the instruction held in the D register and keeps its own shadow pipeline of destination register and Tnew for the E and M stages. It also counts stall cycles for performance debug.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall and D-stage forwarding controller for the 5-stage MIPS core.
// Decodes the D-stage instruction against a shadow E/M pipeline of destination register and Tnew.
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_D,
   output logic             en_PC,
   output logic             en_D,
   output logic             clr,
   output logic [1:0]       fwd_rs_D,
   output logic [1:0]       fwd_rt_D,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       rs;
   logic [4:0]       rt;
   logic [4:0]       rd;
   logic             unused_bits;

   logic             rs_read;
   logic             rt_read;
   logic [1:0]       rs_tuse;
   logic [1:0]       rt_tuse;
   logic [4:0]       a3_dec;
   logic [1:0]       tnew_dec;

   logic [4:0]       e_a3_reg;
   logic [1:0]       e_tnew_reg;
   logic [4:0]       m_a3_reg;
   logic [1:0]       m_tnew_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic             rs_stall;
   logic             rt_stall;
   logic             stall;

   assign op          = instr_D[31:26];
   assign rs          = instr_D[25:21];
   assign rt          = instr_D[20:16];
   assign rd          = instr_D[15:11];
   assign funct       = instr_D[5:0];
   assign unused_bits = ^instr_D[10:6];

   always_comb begin
      rs_read  = 1'b0;
      rt_read  = 1'b0;
      rs_tuse  = 2'd0;
      rt_tuse  = 2'd0;
      a3_dec   = 5'd0;
      tnew_dec = 2'd0;
      case (op)
         6'b000000: begin
            if (funct == 6'b100001 || funct == 6'b100011) begin
               rs_read  = 1'b1;
               rt_read  = 1'b1;
               rs_tuse  = 2'd1;
               rt_tuse  = 2'd1;
               a3_dec   = rd;
               tnew_dec = 2'd1;
            end else if (funct == 6'b001000) begin
               rs_read = 1'b1;
            end
         end
         6'b001101: begin
            rs_read  = 1'b1;
            rs_tuse  = 2'd1;
            a3_dec   = rt;
            tnew_dec = 2'd1;
         end
         6'b001111: begin
            a3_dec   = rt;
            tnew_dec = 2'd1;
         end
         6'b100011: begin
            rs_read  = 1'b1;
            rs_tuse  = 2'd1;
            a3_dec   = rt;
            tnew_dec = 2'd2;
         end
         6'b101011: begin
            rs_read = 1'b1;
            rt_read = 1'b1;
            rs_tuse = 2'd1;
            rt_tuse = 2'd2;
         end
         6'b000100: begin
            rs_read = 1'b1;
            rt_read = 1'b1;
         end
         6'b000011: begin
            a3_dec   = 5'd31;
            tnew_dec = 2'd0;
         end
         default: ;
      endcase
   end

   // A producer still needing more cycles than the consumer can wait forces a stall.
   assign rs_stall = rs_read && (rs != 5'd0) &&
                     (((rs == e_a3_reg) && (e_tnew_reg > rs_tuse)) ||
                      ((rs == m_a3_reg) && (m_tnew_reg > rs_tuse)));
   assign rt_stall = rt_read && (rt != 5'd0) &&
                     (((rt == e_a3_reg) && (e_tnew_reg > rt_tuse)) ||
                      ((rt == m_a3_reg) && (m_tnew_reg > rt_tuse)));
   assign stall    = rs_stall || rt_stall;

   assign en_PC = !stall;
   assign en_D  = !stall;
   assign clr   = stall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                          input logic [4:0] ea3, input logic [1:0] etn,
                                          input logic [4:0] ma3, input logic [1:0] mtn);
      if (r != 5'd0 && r == ea3 && etn == 2'd0)
         return 2'd1;
      else if (r != 5'd0 && r == ma3 && mtn == 2'd0)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   assign fwd_rs_D  = fwd_sel(rs, e_a3_reg, e_tnew_reg, m_a3_reg, m_tnew_reg);
   assign fwd_rt_D  = fwd_sel(rt, e_a3_reg, e_tnew_reg, m_a3_reg, m_tnew_reg);
   assign stall_cnt = stall_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_a3_reg      <= 5'd0;
         e_tnew_reg    <= 2'd0;
         m_a3_reg      <= 5'd0;
         m_tnew_reg    <= 2'd0;
         stall_cnt_reg <= '0;
      end else begin
         e_a3_reg   <= stall ? 5'd0 : a3_dec;
         e_tnew_reg <= stall ? 2'd0 : tnew_dec;
         m_a3_reg   <= e_a3_reg;
         m_tnew_reg <= (e_tnew_reg == 2'd0) ? 2'd0 : e_tnew_reg - 2'd1;
         if (stall && stall_cnt_reg != '1)
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: an age-based in-flight producer model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   localparam logic [31:0] NOP        = 32'h0000_0000;
   localparam logic [31:0] ADDU_2_1_3 = {6'd0, 5'd1, 5'd3, 5'd2, 5'd0, 6'h21};
   localparam logic [31:0] ADDU_2_0_0 = {6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'h21};
   localparam logic [31:0] LW_1       = {6'h23, 5'd0, 5'd1, 16'd0};
   localparam logic [31:0] LW_0       = {6'h23, 5'd0, 5'd0, 16'd0};
   localparam logic [31:0] SW_1       = {6'h2b, 5'd0, 5'd1, 16'd0};
   localparam logic [31:0] BEQ_1_0    = {6'h04, 5'd1, 5'd0, 16'd0};
   localparam logic [31:0] BEQ_5_5    = {6'h04, 5'd5, 5'd5, 16'd0};
   localparam logic [31:0] ORI_5_0_7  = {6'h0d, 5'd0, 5'd5, 16'd7};
   localparam logic [31:0] JAL        = {6'h03, 26'd0};
   localparam logic [31:0] JR_31      = {6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08};

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [31:0]      instr_D = NOP;
   logic             en_PC;
   logic             en_D;
   logic             clr;
   logic [1:0]       fwd_rs_D;
   logic [1:0]       fwd_rt_D;
   logic [CNT_W-1:0] stall_cnt;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .instr_D   (instr_D),
      .en_PC     (en_PC),
      .en_D      (en_D),
      .clr       (clr),
      .fwd_rs_D  (fwd_rs_D),
      .fwd_rt_D  (fwd_rt_D),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   typedef struct {
      bit rs_rd;
      bit rt_rd;
      int rs_tuse;
      int rt_tuse;
      int a3;
      int tnew;
   } dec_t;

   // In-flight producers indexed by age (0 = in E, 1 = in M), holding their Tnew as issued.
   int p_a3[2];
   int p_tnew[2];
   int m_cnt;

   function automatic dec_t decode(logic [31:0] i);
      dec_t d;
      int op;
      int fn;
      d = '{default: 0};
      op = int'(i[31:26]);
      fn = int'(i[5:0]);
      if (op == 0 && (fn == 'h21 || fn == 'h23))
         d = '{1, 1, 1, 1, int'(i[15:11]), 1};
      else if (op == 0 && fn == 'h08)
         d = '{1, 0, 0, 0, 0, 0};
      else if (op == 'h0d)
         d = '{1, 0, 1, 0, int'(i[20:16]), 1};
      else if (op == 'h0f)
         d = '{0, 0, 0, 0, int'(i[20:16]), 1};
      else if (op == 'h23)
         d = '{1, 0, 1, 0, int'(i[20:16]), 2};
      else if (op == 'h2b)
         d = '{1, 1, 1, 2, 0, 0};
      else if (op == 'h04)
         d = '{1, 1, 0, 0, 0, 0};
      else if (op == 'h03)
         d = '{0, 0, 0, 0, 31, 0};
      return d;
   endfunction

   function automatic int remaining(int age);
      int r;
      r = p_tnew[age] - age;
      return (r < 0) ? 0 : r;
   endfunction

   function automatic bit op_stall(bit rd, int r, int tuse);
      if (!rd || r == 0) return 1'b0;
      for (int a = 0; a < 2; a++)
         if (p_a3[a] == r && remaining(a) > tuse) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_stall();
      dec_t d;
      d = decode(instr_D);
      return op_stall(d.rs_rd, int'(instr_D[25:21]), d.rs_tuse) ||
             op_stall(d.rt_rd, int'(instr_D[20:16]), d.rt_tuse);
   endfunction

   function automatic int m_fwd(int r);
      for (int a = 0; a < 2; a++)
         if (r != 0 && p_a3[a] == r && remaining(a) == 0) return a + 1;
      return 0;
   endfunction

   function automatic int dec_a3(logic [31:0] i);
      dec_t d;
      d = decode(i);
      return d.a3;
   endfunction

   function automatic int dec_tnew(logic [31:0] i);
      dec_t d;
      d = decode(i);
      return d.tnew;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_a3[0]  <= 0;
         p_tnew[0] <= 0;
         p_a3[1]  <= 0;
         p_tnew[1] <= 0;
         m_cnt    <= 0;
      end else begin
         p_a3[1]   <= p_a3[0];
         p_tnew[1] <= p_tnew[0];
         if (m_stall()) begin
            p_a3[0]   <= 0;
            p_tnew[0] <= 0;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt <= m_cnt + 1;
         end else begin
            p_a3[0]   <= dec_a3(instr_D);
            p_tnew[0] <= dec_tnew(instr_D);
         end
      end
   end

   task automatic check(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t, instr_D=%h)", name, got, exp, $time, instr_D);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         bit s;
         s = m_stall();
         check("en_PC", int'(en_PC), int'(!s));
         check("en_D", int'(en_D), int'(!s));
         check("clr", int'(clr), int'(s));
         check("fwd_rs_D", int'(fwd_rs_D), m_fwd(int'(instr_D[25:21])));
         check("fwd_rt_D", int'(fwd_rt_D), m_fwd(int'(instr_D[20:16])));
         check("stall_cnt", int'(stall_cnt), m_cnt);
      end
   end

   task automatic apply(logic [31:0] i);
      @(posedge clk);
      #2 instr_D = i;
      #1;
   endtask

   task automatic hold_cycle();
      @(posedge clk);
      #3;
   endtask

   task automatic expect_stall(string name, bit s);
      check({name, "_en_PC"}, int'(en_PC), int'(!s));
      check({name, "_clr"}, int'(clr), int'(s));
   endtask

   initial begin
      #1 reset = 1'b0;
      instr_D = ADDU_2_1_3;
      checking = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("rst_en_PC", int'(en_PC), 1);
      check("rst_en_D", int'(en_D), 1);
      check("rst_clr", int'(clr), 0);
      check("rst_fwd_rs", int'(fwd_rs_D), 0);
      check("rst_cnt", int'(stall_cnt), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      instr_D = NOP;

      // lw -> ALU consumer: one stall cycle
      apply(LW_1);
      apply(ADDU_2_1_3);
      expect_stall("lu_c1", 1'b1);
      check("lu_c1_en_D", int'(en_D), 0);
      hold_cycle();
      expect_stall("lu_c2", 1'b0);
      check("lu_cnt", int'(stall_cnt), 1);

      // lw -> beq: two stall cycles, then W-stage producer needs no forwarding
      apply(NOP);
      apply(LW_1);
      apply(BEQ_1_0);
      expect_stall("lb_c1", 1'b1);
      hold_cycle();
      expect_stall("lb_c2", 1'b1);
      hold_cycle();
      expect_stall("lb_c3", 1'b0);
      check("lb_fwd_rs", int'(fwd_rs_D), 0);
      check("lb_cnt", int'(stall_cnt), 3);

      // ori -> beq: one stall, then both operands forwarded from M
      apply(ORI_5_0_7);
      apply(BEQ_5_5);
      expect_stall("ab_c1", 1'b1);
      hold_cycle();
      expect_stall("ab_c2", 1'b0);
      check("ab_fwd_rs", int'(fwd_rs_D), 2);
      check("ab_fwd_rt", int'(fwd_rt_D), 2);
      check("ab_cnt", int'(stall_cnt), 4);

      // jal -> jr $31: forwarded from E without stalling
      apply(JAL);
      apply(JR_31);
      expect_stall("jj", 1'b0);
      check("jj_fwd_rs", int'(fwd_rs_D), 1);

      // writes to $0 never stall or forward
      apply(LW_0);
      apply(ADDU_2_0_0);
      expect_stall("z0", 1'b0);
      check("z0_fwd_rs", int'(fwd_rs_D), 0);
      check("z0_fwd_rt", int'(fwd_rt_D), 0);

      // lw -> sw data operand: no stall
      apply(LW_1);
      apply(SW_1);
      expect_stall("ls", 1'b0);
      check("ls_fwd_rt", int'(fwd_rt_D), 0);

      // reset pulse during the first lw -> beq stall cycle
      apply(LW_1);
      apply(BEQ_1_0);
      expect_stall("mr_pre", 1'b1);
      #1 reset = 1'b0;
      #1;
      expect_stall("mr_in", 1'b0);
      check("mr_fwd_rs", int'(fwd_rs_D), 0);
      check("mr_cnt", int'(stall_cnt), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      hold_cycle();
      expect_stall("mr_post", 1'b0);
      check("mr_post_cnt", int'(stall_cnt), 0);

      // 17 load-use stalls saturate the 4-bit counter
      for (int k = 0; k < 17; k++) begin
         apply(LW_1);
         apply(ADDU_2_1_3);
         hold_cycle();
      end
      check("sat_cnt", int'(stall_cnt), 15);
      apply(NOP);
      hold_cycle();

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
